// File: rtl/cache_defs.sv
// rtl/cache_defs.sv - shared instruction-cache definitions for the line fill engine
package cache_defs;

   localparam int ICACHE_LINE_WIDTH = 128;
   localparam int ICACHE_BUS_WIDTH  = 32;
   localparam int ICACHE_ADDR_WIDTH = 32;
   localparam int ICACHE_BEATS      = ICACHE_LINE_WIDTH / ICACHE_BUS_WIDTH;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'd0,
      FILL_REQ   = 2'd1,
      FILL_DRAIN = 2'd2,
      FILL_DONE  = 2'd3
   } type_icache_fill_states_e;

endpackage

// File: rtl/icache_mem_fill_if.sv
// rtl/icache_mem_fill_if.sv - cache-side and bus-side signal bundle of the line fill engine
interface icache_mem_fill_if #(
   parameter int ICACHE_LINE_WIDTH = cache_defs::ICACHE_LINE_WIDTH,
   parameter int ICACHE_BUS_WIDTH  = cache_defs::ICACHE_BUS_WIDTH,
   parameter int ICACHE_ADDR_WIDTH = cache_defs::ICACHE_ADDR_WIDTH
);
   import cache_defs::*;

   logic                         icache2mem_req_i;
   logic [ICACHE_ADDR_WIDTH-1:0] icache2mem_addr_i;
   logic                         icache2mem_kill_i;
   logic                         mem2icache_ack_o;
   logic [ICACHE_LINE_WIDTH-1:0] mem2icache_data_o;

   logic                         bus_req_o;
   logic [ICACHE_ADDR_WIDTH-1:0] bus_addr_o;
   logic                         bus_ack_i;
   logic [ICACHE_BUS_WIDTH-1:0]  bus_rdata_i;

   // master is the fill engine; slave is the cache plus memory bus around it
   modport master (
      input  icache2mem_req_i, icache2mem_addr_i, icache2mem_kill_i, bus_ack_i, bus_rdata_i,
      output mem2icache_ack_o, mem2icache_data_o, bus_req_o, bus_addr_o
   );

   modport slave (
      output icache2mem_req_i, icache2mem_addr_i, icache2mem_kill_i, bus_ack_i, bus_rdata_i,
      input  mem2icache_ack_o, mem2icache_data_o, bus_req_o, bus_addr_o
   );

endinterface

// File: rtl/icache_mem_fill.sv
// rtl/icache_mem_fill.sv - fetches one cache line as sequential single-beat bus reads
module icache_mem_fill #(
   parameter int ICACHE_LINE_WIDTH = cache_defs::ICACHE_LINE_WIDTH,
   parameter int ICACHE_BUS_WIDTH  = cache_defs::ICACHE_BUS_WIDTH,
   parameter int ICACHE_ADDR_WIDTH = cache_defs::ICACHE_ADDR_WIDTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   icache_mem_fill_if.master mem_if
);
   import cache_defs::*;

   localparam int BEATS      = ICACHE_LINE_WIDTH / ICACHE_BUS_WIDTH;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LINE_BYTES = ICACHE_LINE_WIDTH / 8;
   localparam int BUS_OFF    = $clog2(ICACHE_BUS_WIDTH / 8);
   localparam logic [ICACHE_ADDR_WIDTH-1:0] LINE_MASK = ICACHE_ADDR_WIDTH'(LINE_BYTES - 1);
   localparam logic [CNT_W-1:0]             LAST_BEAT = CNT_W'(BEATS - 1);

   type_icache_fill_states_e     state_q, state_d;
   logic [ICACHE_ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [ICACHE_LINE_WIDTH-1:0] line_q, line_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FILL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         base_q <= '0;
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         base_q <= base_d;
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      case (state_q)
         FILL_IDLE: begin
            if (mem_if.icache2mem_req_i && !mem_if.icache2mem_kill_i) begin
               base_d  = mem_if.icache2mem_addr_i & ~LINE_MASK;
               cnt_d   = '0;
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (mem_if.bus_ack_i) begin
               if (mem_if.icache2mem_kill_i) begin
                  state_d = FILL_IDLE;
               end else begin
                  // beats land straight in the output register, beat 0 at the LSBs
                  line_d[int'(cnt_q) * ICACHE_BUS_WIDTH +: ICACHE_BUS_WIDTH] = mem_if.bus_rdata_i;
                  if (cnt_q == LAST_BEAT) begin
                     cnt_d   = '0;
                     state_d = FILL_DONE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end else if (mem_if.icache2mem_kill_i) begin
               state_d = FILL_DRAIN;
            end
         end
         // the outstanding beat must still complete on the bus; its data is dropped
         FILL_DRAIN: begin
            if (mem_if.bus_ack_i) begin
               state_d = FILL_IDLE;
            end
         end
         FILL_DONE: begin
            state_d = FILL_IDLE;
         end
         default: begin
            state_d = FILL_IDLE;
         end
      endcase
   end

   assign mem_if.bus_req_o         = (state_q == FILL_REQ) || (state_q == FILL_DRAIN);
   assign mem_if.bus_addr_o        = base_q + (ICACHE_ADDR_WIDTH'(cnt_q) << BUS_OFF);
   assign mem_if.mem2icache_ack_o  = (state_q == FILL_DONE);
   assign mem_if.mem2icache_data_o = line_q;

endmodule

// File: doc/icache_mem_fill.md
ICACHE_MEM_FILL -- requirements
Module: icache_mem_fill

Interface
REQ-001 SHALL have parameter ICACHE_LINE_WIDTH, default 128, cache line width in bits.
REQ-002 SHALL have parameter ICACHE_BUS_WIDTH, default 32, memory bus data width in bits.
REQ-003 SHALL have parameter ICACHE_ADDR_WIDTH, default 32, byte address width.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  input  1  sole clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
REQ-005 Cache-side ports:
- icache2mem_req_i  input  1  line fill request, level, held until ack or kill.
- icache2mem_addr_i  input  ICACHE_ADDR_WIDTH  miss byte address.
- icache2mem_kill_i  input  1  abandon current fill.
- mem2icache_ack_o  output  1  one-cycle pulse, line valid.
- mem2icache_data_o  output  ICACHE_LINE_WIDTH  assembled line.
REQ-006 Bus-side ports:
- bus_req_o  output  1  beat read request.
- bus_addr_o  output  ICACHE_ADDR_WIDTH  word-aligned beat address.
- bus_ack_i  input  1  beat complete, bus_rdata_i valid.
- bus_rdata_i  input  ICACHE_BUS_WIDTH  beat read data.

Function
REQ-007 SHALL derive BEATS = ICACHE_LINE_WIDTH/ICACHE_BUS_WIDTH (default 4) and a beat counter of clog2(BEATS) bits.
REQ-008 SHALL implement states FILL_IDLE, FILL_REQ, FILL_DRAIN, FILL_DONE.
REQ-009 FILL_IDLE: on icache2mem_req_i=1 and icache2mem_kill_i=0, SHALL latch line base address (miss address, low clog2(ICACHE_LINE_WIDTH/8) bits cleared), clear beat counter, go FILL_REQ.
REQ-010 FILL_IDLE: kill alone SHALL be ignored.
REQ-011 FILL_REQ: bus_req_o=1, bus_addr_o = base + counter*(ICACHE_BUS_WIDTH/8); address and request held stable until bus_ack_i.
REQ-012 On bus_ack_i in FILL_REQ, SHALL write bus_rdata_i into line slice [counter] (beat 0 = least-significant bits) and increment counter.
REQ-013 After the ack of beat BEATS-1 with no kill, SHALL go FILL_DONE; counter wraps to 0.
REQ-014 FILL_DONE: mem2icache_ack_o=1 for exactly one cycle, bus_req_o=0, then FILL_IDLE; icache2mem_req_i ignored in this cycle.
REQ-015 mem2icache_data_o SHALL be registered and hold the last completed line until the next fill's first beat write.
REQ-016 Kill in FILL_REQ with bus_ack_i=1 same cycle: beat data discarded, go FILL_IDLE, no mem2icache_ack_o.
REQ-017 Kill in FILL_REQ with bus_ack_i=0: go FILL_DRAIN; bus_req_o and bus_addr_o SHALL stay asserted/stable (bus request never withdrawn before ack).
REQ-018 FILL_DRAIN: on bus_ack_i discard data, go FILL_IDLE; no mem2icache_ack_o; further kills ignored.
REQ-019 Kill coincident with final beat ack SHALL suppress mem2icache_ack_o.
REQ-020 Latency: bus_req_o rises the cycle after request acceptance; mem2icache_ack_o rises the cycle after the final beat ack; zero-wait bus gives ack 5 cycles after acceptance (default BEATS).
REQ-021 At most one beat outstanding at any time.

Reset
REQ-022 rst_i SHALL asynchronously force FILL_IDLE, counter 0, base address 0, bus_req_o 0, mem2icache_ack_o 0, mem2icache_data_o 0.
REQ-023 Reset mid-fill SHALL abandon the fill without draining; post-reset first request starts from beat 0.

Structure
REQ-024 type_icache_fill_states_e, ICACHE_LINE_WIDTH, ICACHE_BUS_WIDTH and beat count SHALL live in the shared cache_defs package.
REQ-025 No sub-module; counter, address and line register SHALL be inline.

Verification
REQ-026 Zero-wait fill, addr 0x8000_0014, rdata 0x11,0x22,0x33,0x44 -> bus_addr 0x8000_0010/14/18/1C, data 0x00000044_00000033_00000022_00000011, ack pulse cycle 5.
REQ-027 Bus ack delayed 3 cycles per beat -> bus_req_o/bus_addr_o stable during waits, one ack pulse after beat 3.
REQ-028 Kill during beat 1 with no ack -> FILL_DRAIN, bus_req_o held to ack, no mem2icache_ack_o, data_o unchanged.
REQ-029 Kill coincident with beat 3 ack -> no mem2icache_ack_o, FILL_IDLE next cycle.
REQ-030 rst_i asserted mid-beat 2 -> all outputs 0 immediately; new request at 0x0000_0100 fetches beats 0x100..0x10C.
REQ-031 Back-to-back fills, request reasserted cycle after ack -> second fill starts beat 0, no stale data.
